// File: rtl/io_panel_pkg.sv
// io_panel_pkg: shared constants for the switch/display panel.
// Glyph table is active-low, bit0 = segment a .. bit6 = segment g.
package io_panel_pkg;
    localparam int SCAN_DIV_DEF  = 50000;
    localparam int DB_CYCLES_DEF = 500000;
    typedef logic [6:0] seg_t;
    localparam seg_t [15:0] GLYPH = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
endpackage

// File: rtl/io_panel_if.sv
// io_panel_if: board-side switch/display bus of the panel.
interface io_panel_if;
    logic [15:0] sw;
    logic [15:0] result;
    logic [7:0]  opr1;
    logic [7:0]  opr2;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        sw_changed;
    modport master (output sw, result, input opr1, opr2, seg_n, an_n, sw_changed);
    modport slave  (input sw, result, output opr1, opr2, seg_n, an_n, sw_changed);
endinterface

// File: rtl/io_panel_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment glyph.
module hex_to_seg
    import io_panel_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);
    always_comb seg_o = GLYPH[nib_i];
endmodule

// File: rtl/io_panel.sv
// io_panel: switch synchronizer/debouncer feeding operands, plus a
// 4-digit multiplexed hex display of the result register.
module io_panel
    import io_panel_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    io_panel_if.slave bus
);
    localparam int SCW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    logic [15:0]    sync1_q, sync2_q, prev_q, stable_q;
    logic [DBW-1:0] db_q;
    logic           changed_q;
    logic [SCW-1:0] scan_q, scan_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    frame_q, frame_d;
    logic [3:0]     an_q, nib;
    seg_t           seg_q, glyph;
    logic           wrap;
    // Segments are decoded from the next-state index/frame so anode and glyph land together.
    always_comb begin
        wrap    = scan_q == SCW'(SCAN_DIV - 1);
        scan_d  = wrap ? '0 : scan_q + SCW'(1);
        idx_d   = idx_q + 2'(wrap);
        frame_d = (wrap && idx_q == 2'd3) ? bus.result : frame_q;
        nib     = frame_d[{idx_d, 2'b00} +: 4];
    end
    hex_to_seg u_hex (.nib_i(nib), .seg_o(glyph));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            db_q      <= '0;
            changed_q <= 1'b0;
            scan_q    <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            an_q      <= 4'b1110;
            seg_q     <= GLYPH[0];
        end else begin
            sync1_q   <= bus.sw;
            sync2_q   <= sync1_q;
            changed_q <= 1'b0;
            if (sync2_q != prev_q) begin
                prev_q <= sync2_q;
                db_q   <= '0;
            end else if (prev_q == stable_q) begin
                db_q <= '0;
            end else if (db_q == DBW'(DB_CYCLES - 1)) begin
                stable_q  <= prev_q;
                db_q      <= '0;
                changed_q <= 1'b1;
            end else begin
                db_q <= db_q + DBW'(1);
            end
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= ~(4'b0001 << idx_d);
            seg_q   <= glyph;
        end
    end
    assign bus.opr1       = stable_q[7:0];
    assign bus.opr2       = stable_q[15:8];
    assign bus.sw_changed = changed_q;
    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
endmodule
